// File: rtl/pipe_pkg.sv
// Shared definitions for the handshake pipeline stage.
//   OCC_W   : width of the occupancy count (0, 1 or 2 entries)
//   state_t : stage state; the encoding equals the number of valid entries,
//             so occupancy is driven straight from the state register.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

endpackage

// File: rtl/reg_arstn_en.sv
// Payload register with load enable and asynchronous active-low reset.
//   clk    : rising-edge clock
//   arst_n : asynchronous reset, active-low; loads PRESET_VAL
//   en     : load enable
//   din    : value loaded when en=1
//   q      : registered value, holds when en=0
module reg_arstn_en #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] PRESET_VAL = '0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q <= PRESET_VAL;
    end else if (en) begin
      q <= din;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake.
// SKID=1: two entries (main + skid) so in_ready can come from a flop,
//         cutting the backpressure path while keeping full throughput.
// SKID=0: single entry, in_ready is combinational from out_ready.
// flush squashes all held entries to PRESET_VAL bubbles.
//   clk, arst_n : clock (rising edge), asynchronous active-low reset
//   flush       : synchronous squash of held entries; blocks input that cycle
//   in_valid, in_ready, in_data    : upstream handshake and payload
//   out_valid, out_ready, out_data : downstream handshake, main entry payload
//   occupancy   : number of valid entries (0..2)
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] PRESET_VAL = '0,
  parameter bit                SKID       = 1'b1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  state_t            state, next_state;
  logic              in_ready_q;
  logic              in_fire, out_fire;
  logic              main_en, skid_en;
  logic [DATA_W-1:0] main_din, skid_din, skid_q;

  assign out_valid = (state != ST_EMPTY);
  assign occupancy = state;
  assign in_ready  = SKID ? (in_ready_q && !flush)
                          : (!flush && (!out_valid || out_ready));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // ---- control: state register and registered ready ----
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state != ST_SKID);
    end
  end

  always_comb begin
    next_state = state;
    main_en    = 1'b0;
    main_din   = in_data;
    skid_en    = 1'b0;
    skid_din   = in_data;
    if (flush) begin
      // A downstream transfer this cycle still completes; the entry is dropped.
      next_state = ST_EMPTY;
      main_en    = 1'b1;
      main_din   = PRESET_VAL;
      skid_en    = 1'b1;
      skid_din   = PRESET_VAL;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            next_state = ST_FULL;
            main_en    = 1'b1;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            // Only reachable with SKID=1; single-entry ready requires out_ready.
            if (SKID) begin
              next_state = ST_SKID;
              skid_en    = 1'b1;
            end
          end else if (out_fire) begin
            next_state = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            next_state = ST_FULL;
            main_en    = 1'b1;
            main_din   = skid_q;
          end
        end
        default: next_state = ST_EMPTY;
      endcase
    end
  end

  // ---- payload storage ----
  reg_arstn_en #(.DATA_W(DATA_W), .PRESET_VAL(PRESET_VAL)) u_main (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (main_en),
    .din    (main_din),
    .q      (out_data)
  );

  reg_arstn_en #(.DATA_W(DATA_W), .PRESET_VAL(PRESET_VAL)) u_skid (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (skid_en),
    .din    (skid_din),
    .q      (skid_q)
  );

  // A stalled valid entry may only disappear through a flush.
  property p_valid_held;
    @(posedge clk) disable iff (!arst_n)
      (out_valid && !out_ready && !flush) |=> out_valid;
  endproperty
  a_valid_held: assert property (p_valid_held);

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int             DW = 16;
  localparam logic [DW-1:0]  PV = 16'hA5A5;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  // SKID=1 instance
  logic          flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  // SKID=0 instance
  logic          s0_flush = 1'b0, s0_in_valid = 1'b0, s0_out_ready = 1'b0;
  logic [DW-1:0] s0_in_data = '0;
  logic          s0_in_ready, s0_out_valid;
  logic [DW-1:0] s0_out_data;
  logic [1:0]    s0_occupancy;

  pipe_stage_skid #(.DATA_W(DW), .PRESET_VAL(PV), .SKID(1'b1)) dut (
    .clk(clk), .arst_n(arst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_skid #(.DATA_W(DW), .PRESET_VAL(PV), .SKID(1'b0)) dut0 (
    .clk(clk), .arst_n(arst_n), .flush(s0_flush),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
    .occupancy(s0_occupancy)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: each stage is a bounded FIFO of held payloads.
  // head = payload the main register shows (last head, or PV after reset/flush).
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] head1, head0;
  bit            rdy1;  // registered ready of the skid stage: not full last edge

  function automatic logic [19:0] exp1();
    exp1 = {q1.size() != 0, head1, 2'(q1.size()), !flush && rdy1};
  endfunction

  function automatic logic [19:0] exp0();
    exp0 = {q0.size() != 0, head0, 2'(q0.size()),
            !s0_flush && (q0.size() == 0 || s0_out_ready)};
  endfunction

  task automatic model_reset();
    q1.delete(); q0.delete();
    head1 = PV; head0 = PV; rdy1 = 1'b1;
  endtask

  // Advance both models across one rising edge; returns input-accept flags.
  task automatic step(output bit f1, output bit f0);
    bit o1, o0;
    f1 = in_valid && !flush && rdy1;
    o1 = (q1.size() != 0) && out_ready;
    f0 = s0_in_valid && !s0_flush && (q0.size() == 0 || s0_out_ready);
    o0 = (q0.size() != 0) && s0_out_ready;
    @(posedge clk);
    if (flush) begin q1.delete(); head1 = PV; end
    else begin
      if (o1) void'(q1.pop_front());
      if (f1) q1.push_back(in_data);
    end
    if (q1.size() != 0) head1 = q1[0];
    rdy1 = (q1.size() != 2);
    if (s0_flush) begin q0.delete(); head0 = PV; end
    else begin
      if (o0) void'(q0.pop_front());
      if (f0) q0.push_back(s0_in_data);
    end
    if (q0.size() != 0) head0 = q0[0];
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== {1'b0, PV, 2'd0, 1'b1}) begin
      $display("FAIL reset_skid1: got %h want %h", {out_valid, out_data, occupancy, in_ready}, {1'b0, PV, 2'd0, 1'b1});
    end else passes++;
    checks++;
    if ({s0_out_valid, s0_out_data, s0_occupancy, s0_in_ready} !== {1'b0, PV, 2'd0, 1'b1}) begin
      $display("FAIL reset_skid0: got %h want %h", {s0_out_valid, s0_out_data, s0_occupancy, s0_in_ready}, {1'b0, PV, 2'd0, 1'b1});
    end else passes++;
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== exp1()) begin
      $display("FAIL reset_release: got %h want %h", {out_valid, out_data, occupancy, in_ready}, exp1());
    end else passes++;
  endtask

  task automatic test_stream();
    bit f1, f0;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      #1;
      checks++;
      if ({out_valid, out_data, occupancy, in_ready} !== exp1() || in_ready !== 1'b1 || occupancy > 2'd1) begin
        $display("FAIL stream_pre%0d: got %h want %h", i, {out_valid, out_data, occupancy, in_ready}, exp1());
      end else passes++;
      step(f1, f0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(i)) begin
        $display("FAIL stream_lat%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, DW'(i));
      end else passes++;
    end
    in_valid = 1'b0;
    step(f1, f0);
  endtask

  task automatic test_backpressure();
    bit f1, f0;
    logic [DW-1:0] want[3];
    want[0] = 16'h000A; want[1] = 16'h000B; want[2] = 16'h000C;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h000A; #1; step(f1, f0);
    in_data = 16'h000B; #1; step(f1, f0);
    in_data = 16'h000C; #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (occupancy !== 2'd2 || in_ready !== 1'b0 || {out_valid, out_data, occupancy, in_ready} !== exp1()) begin
        $display("FAIL bp_full%0d: got occ=%0d rdy=%b want occ=2 rdy=0", k, occupancy, in_ready);
      end else passes++;
      step(f1, f0);
      #1;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== want[k] || {out_valid, out_data, occupancy, in_ready} !== exp1()) begin
        $display("FAIL bp_drain%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, want[k]);
      end else passes++;
      step(f1, f0);
      if (f1) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      $display("FAIL bp_empty: got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid);
    end else passes++;
  endtask

  task automatic test_flush();
    bit f1, f0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0011; #1; step(f1, f0);
    in_data = 16'h0022; #1; step(f1, f0);
    flush = 1'b1; in_data = 16'h0033; #1;
    checks++;
    if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
      $display("FAIL flush_cycle: got rdy=%b occ=%0d want rdy=0 occ=2", in_ready, occupancy);
    end else passes++;
    step(f1, f0);
    flush = 1'b0; in_valid = 1'b0; #1;
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== {1'b0, PV, 2'd0, 1'b1}) begin
      $display("FAIL flush_after: got %h want %h", {out_valid, out_data, occupancy, in_ready}, {1'b0, PV, 2'd0, 1'b1});
    end else passes++;
    step(f1, f0);
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== exp1() || out_valid !== 1'b0) begin
      $display("FAIL flush_nocapture: got %h want %h", {out_valid, out_data, occupancy, in_ready}, exp1());
    end else passes++;
  endtask

  task automatic test_simultaneous();
    bit f1, f0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0044; #1; step(f1, f0);
    in_data = 16'h0055; out_ready = 1'b1; #1;
    checks++;
    if (out_data !== 16'h0044 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      $display("FAIL simul_pre: got d=%h occ=%0d rdy=%b want d=0044 occ=1 rdy=1", out_data, occupancy, in_ready);
    end else passes++;
    step(f1, f0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0055 || occupancy !== 2'd1) begin
      $display("FAIL simul_post: got v=%b d=%h occ=%0d want v=1 d=0055 occ=1", out_valid, out_data, occupancy);
    end else passes++;
    in_valid = 1'b0;
    step(f1, f0);
  endtask

  task automatic test_reset_mid();
    bit f1, f0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0061; #1; step(f1, f0);
    in_data = 16'h0062; #1; step(f1, f0);
    in_valid = 1'b0; #1;
    checks++;
    if (occupancy !== 2'd2 || out_data !== 16'h0061) begin
      $display("FAIL rstmid_pre: got occ=%0d d=%h want occ=2 d=0061", occupancy, out_data);
    end else passes++;
    arst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== {1'b0, PV, 2'd0, 1'b1}) begin
      $display("FAIL rstmid_async: got %h want %h", {out_valid, out_data, occupancy, in_ready}, {1'b0, PV, 2'd0, 1'b1});
    end else passes++;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    in_valid = 1'b1; in_data = 16'h0007; out_ready = 1'b1; #1;
    step(f1, f0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0007) begin
      $display("FAIL rstmid_stream: got v=%b d=%h want v=1 d=0007", out_valid, out_data);
    end else passes++;
    in_valid = 1'b0;
    step(f1, f0);
  endtask

  task automatic test_random_skid1();
    bit f1, f0;
    bit prev_fire;
    int bad;
    prev_fire = 1'b1;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      if (!(in_valid && !prev_fire)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = DW'($urandom);
      end
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      checks++;
      if ({out_valid, out_data, occupancy, in_ready} !== exp1()) begin
        bad++;
        if (bad <= 5) $display("FAIL rand1_c%0d: got %h want %h", c, {out_valid, out_data, occupancy, in_ready}, exp1());
      end else passes++;
      step(f1, f0);
      prev_fire = f1;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(f1, f0); step(f1, f0);
  endtask

  task automatic test_skid0();
    bit f1, f0;
    bit prev_fire;
    int bad;
    prev_fire = 1'b1;
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      if (!(s0_in_valid && !prev_fire)) begin
        s0_in_valid = 1'($urandom_range(0, 3) != 0);
        s0_in_data  = DW'($urandom);
      end
      s0_out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (s0_in_ready !== (!s0_out_valid || s0_out_ready) || s0_occupancy > 2'd1 ||
          {s0_out_valid, s0_out_data, s0_occupancy, s0_in_ready} !== exp0()) begin
        bad++;
        if (bad <= 5) $display("FAIL skid0_c%0d: got %h want %h", c, {s0_out_valid, s0_out_data, s0_occupancy, s0_in_ready}, exp0());
      end else passes++;
      step(f1, f0);
      prev_fire = f0;
    end
    s0_in_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    arst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_simultaneous();
    test_reset_mid();
    test_random_skid1();
    test_skid0();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
